// File: rtl/alu_issue_stage.sv
// Valid/ready issue and in-order retire wrapper for a registered float32 alu.
// Credits bound the in-flight work so a capture always finds room in the result buffer.
module alu_issue_stage #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int PL = ALU_LAT + 1;
  localparam int RB = ALU_LAT + 1;
  localparam int RW = (RB > 1) ? $clog2(RB) : 1;
  localparam int NW = $clog2(RB + 1);
  localparam int CW = $clog2(PL + 1);

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic [RW-1:0] rb_next(input logic [RW-1:0] p);
    return (p == RW'(RB - 1)) ? {RW{1'b0}} : RW'(p + 1'b1);
  endfunction

  logic [31:0]      fa_r   [DEPTH];
  logic [31:0]      fb_r   [DEPTH];
  logic [1:0]       fop_r  [DEPTH];
  logic [TAG_W-1:0] ftag_r [DEPTH];
  logic [AW:0]      wptr_r, rptr_r;

  logic             pv_r    [PL];
  logic [TAG_W-1:0] ptag_r  [PL];
  logic [1:0]       pflag_r [PL];

  logic [31:0]      rd_r [RB];
  logic [TAG_W-1:0] rt_r [RB];
  logic [1:0]       rf_r [RB];
  logic [RW-1:0]    rwp_r, rrp_r;
  logic [NW-1:0]    rcnt_r;
  logic [CW-1:0]    credits_r;

  logic             full_s, empty_s, push_s, issue_s, capture_s, pop_s;
  logic [31:0]      head_a_s, head_b_s;
  logic [1:0]       head_op_s, issue_flags_s;
  logic [TAG_W-1:0] head_tag_s;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty_s = (wptr_r == rptr_r);
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;
  assign issue_s  = !empty_s && (credits_r != {CW{1'b0}});
  assign capture_s = pv_r[PL-1];
  assign res_valid = (rcnt_r != {NW{1'b0}});
  assign pop_s     = res_valid && res_ready;

  assign head_a_s   = fa_r[rptr_r[AW-1:0]];
  assign head_b_s   = fb_r[rptr_r[AW-1:0]];
  assign head_op_s  = fop_r[rptr_r[AW-1:0]];
  assign head_tag_s = ftag_r[rptr_r[AW-1:0]];
  assign issue_flags_s = {is_nan(head_a_s) || is_nan(head_b_s),
                          is_inf(head_a_s) || is_inf(head_b_s)};

  assign res_data  = rd_r[rrp_r];
  assign res_tag   = rt_r[rrp_r];
  assign res_flags = rf_r[rrp_r];

  // Input FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fa_r[i]   <= 32'd0;
        fb_r[i]   <= 32'd0;
        fop_r[i]  <= 2'd0;
        ftag_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fa_r[wptr_r[AW-1:0]]   <= in_a;
        fb_r[wptr_r[AW-1:0]]   <= in_b;
        fop_r[wptr_r[AW-1:0]]  <= in_op;
        ftag_r[wptr_r[AW-1:0]] <= in_tag;
        wptr_r <= wptr_r + 1'b1;
      end
      if (issue_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
    end
  end

  // Alu operand registers, held between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 32'd0;
      alu_b  <= 32'd0;
      alu_op <= 2'd0;
    end else if (issue_s) begin
      alu_a  <= head_a_s;
      alu_b  <= head_b_s;
      alu_op <= head_op_s;
    end
  end

  // Shadow pipe tracking which alu cycles carry a live operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PL; i++) begin
        pv_r[i]    <= 1'b0;
        ptag_r[i]  <= '0;
        pflag_r[i] <= 2'd0;
      end
    end else begin
      pv_r[0]    <= issue_s;
      ptag_r[0]  <= head_tag_s;
      pflag_r[0] <= issue_flags_s;
      for (int i = 1; i < PL; i++) begin
        pv_r[i]    <= pv_r[i-1];
        ptag_r[i]  <= ptag_r[i-1];
        pflag_r[i] <= pflag_r[i-1];
      end
    end
  end

  // Result buffer: capture from the alu, pop toward the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwp_r  <= '0;
      rrp_r  <= '0;
      rcnt_r <= '0;
      for (int i = 0; i < RB; i++) begin
        rd_r[i] <= 32'd0;
        rt_r[i] <= '0;
        rf_r[i] <= 2'd0;
      end
    end else begin
      if (capture_s) begin
        rd_r[rwp_r] <= alu_o;
        rt_r[rwp_r] <= ptag_r[PL-1];
        rf_r[rwp_r] <= pflag_r[PL-1];
        rwp_r <= rb_next(rwp_r);
      end
      if (pop_s) begin
        rrp_r <= rb_next(rrp_r);
      end
      rcnt_r <= rcnt_r + NW'(capture_s) - NW'(pop_s);
    end
  end

  // One credit per result slot; issue spends one, pop returns one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r <= CW'(PL);
    end else begin
      credits_r <= credits_r - CW'(issue_s) + CW'(pop_s);
    end
  end

endmodule
